sync_hs_arbiter: RTL and testbench
==================================

# sync_hs_arbiter

Source-domain controller that shares one `sync_level` crossing between REQ_NUM requesters. It runs a four-phase level handshake over the crossing: it drives `sig_level_source` and waits for `ack_level`, the level returned through a second `sync_level` in the opposite direction. Arbitration is round-robin. A bundled data word and requester ID are held stable for the full handshake, so the destination samples them only after its synchronized level rises. The block sits entirely in `clk_source`, between local requesters and the forward/return synchronizer pair.

## Interface
Parameters:
- `REQ_NUM`, 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, 8: width of the bundled data word.
- `TIMEOUT_CYC`, 255: handshake-phase timeout in `clk_source` cycles; legal range 2..65535. Used only when the timeout feature is compiled in.

Ports:
- `clk_source`  in  1  Single clock (source domain).
- `rst_source`  in  1  Reset; synchronous, active-high.
- `req_valid`  in  REQ_NUM  Per-requester request. Each requester holds its bit until its `req_ready` bit pulses.
- `req_data`  in  REQ_NUM*DATA_WIDTH  Per-requester data. Requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  REQ_NUM  One-hot, 1-cycle pulse: request accepted.
- `done`  out  REQ_NUM  One-hot, 1-cycle pulse: that requester's transfer has completed.
- `sig_level_source`  out  1  Level driven into the forward synchronizer.
- `xfer_data`  out  DATA_WIDTH  Bundled data; stable whenever `busy`=1.
- `xfer_id`  out  $clog2(REQ_NUM)  Index of the granted requester; stable whenever `busy`=1.
- `ack_level`  in  1  Returned acknowledge, already synchronized into `clk_source`.
- `busy`  out  1  High in the REQ_HI and REQ_LO states.
- `timeout_err`  out  1  1-cycle pulse when a handshake phase times out.

## Operation
- FSM states: IDLE, REQ_HI, REQ_LO.
- **IDLE:** If `req_valid`≠0 and `ack_level`=0, grant the winner and go to REQ_HI. On that edge:
  - register `sig_level_source`=1 and `busy`=1;
  - capture `xfer_data`=req_data[winner] and `xfer_id`=winner;
  - pulse `req_ready[winner]`.
- **IDLE with stale ack:** If `ack_level`=1 in IDLE, no grant is made; wait for `ack_level`=0.
- **REQ_HI:** Hold all outputs. When `ack_level`=1 is sampled, drop `sig_level_source` to 0 and go to REQ_LO.
- **REQ_LO:** When `ack_level`=0 is sampled, go to IDLE, pulse `done[xfer_id]` and clear `busy`. `xfer_data` and `xfer_id` keep their last values.
- **Round-robin:** `rr_ptr` resets to 0. Search starts at `rr_ptr` and wraps modulo REQ_NUM; the first set `req_valid` bit wins. After a grant, `rr_ptr`=winner+1, wrapping REQ_NUM-1 to 0.
- **Requests while busy:** `req_valid` bits are not examined outside IDLE. A granted requester's `req_valid` in the `req_ready` cycle is ignored.
- **Reset values:** state IDLE; `rr_ptr`=0; `sig_level_source`=0; `req_ready`=0; `done`=0; `xfer_data`=0; `xfer_id`=0; `busy`=0; `timeout_err`=0.
- **Reset mid-transfer:** `sig_level_source` goes to 0 on the reset edge. No `done` pulse is generated. After reset, the IDLE stale-ack rule prevents a new grant until the return path has drained.

## Timing
- **Grant:** `req_valid` sampled at edge k → at edge k, `sig_level_source`, `busy` and `req_ready` are registered; `req_ready` is visible for exactly 1 cycle after edge k.
- **Output registration:** all outputs are registered; there are no combinational input-to-output paths.
- **Minimum transfer:** IDLE→REQ_HI→REQ_LO→IDLE takes at least 3 cycles. The real duration is set by the round-trip synchronizer latency, which is at least 2×SYNC_STAGE cycles of each clock.
- **Back-to-back grants:** the earliest next grant is at the edge following the `done` pulse, provided `ack_level`=0.
- **Holding the level:** `sig_level_source` stays high until the acknowledge is observed. The 2× clock-ratio requirement of `sync_level` therefore does not apply to this path.

## Configuration
- Macro: `SYNC_HS_TIMEOUT_EN`.
- **Defined:** a 16-bit phase counter clears on every state change and increments each cycle in REQ_HI and REQ_LO.
  - REQ_HI timeout: when the counter reaches TIMEOUT_CYC-1 with `ack_level`=0, pulse `timeout_err`, drop `sig_level_source` and go to REQ_LO.
  - REQ_LO timeout: when the counter reaches TIMEOUT_CYC-1 with `ack_level`=1, pulse `timeout_err` and go to IDLE without a `done` pulse.
- **Undefined:** there is no counter, `timeout_err` is tied to 0, and both states wait indefinitely.

## Test plan
- **Single request:** REQ_NUM=4, `req_valid`=4'b0100, `req_data[2]`=8'hA5. Return ack = `sig_level_source` delayed 6 cycles.
  - Expect `req_ready`=4'b0100 for 1 cycle, `xfer_data`=8'hA5 and `xfer_id`=2 stable while `busy`=1.
  - Expect `sig_level_source` high for 7 cycles, then a single pulse `done`=4'b0100.
- **Round-robin:** all four `req_valid` bits held continuously.
  - Expect grant order 0,1,2,3,0 and exactly one `done` per transfer.
- **Stale ack:** `ack_level` forced to 1 in IDLE with `req_valid`=4'b0001.
  - Expect no `req_ready` pulse until 1 cycle after `ack_level` falls.
- **Reset mid-transfer:** `rst_source` asserted in REQ_HI.
  - Expect `sig_level_source`=0 and `busy`=0 the next cycle, no `done` pulse, and `rr_ptr` back to 0.
- **Timeout:** `SYNC_HS_TIMEOUT_EN` defined, TIMEOUT_CYC=8, `ack_level` stuck at 0.
  - Expect `timeout_err` pulse 8 cycles after the grant, `sig_level_source` falling, return to IDLE, and no `done` pulse.

Source files
------------

// File: rtl/sync_hs_arbiter.sv
// sync_hs_arbiter
//   Source-domain controller sharing one level-synchronizer crossing between REQ_NUM
//   requesters. A four-phase level handshake runs over the crossing: sig_level_source is
//   raised and held until ack_level (the returned level) is seen high, then lowered until
//   ack_level is seen low. Round-robin arbitration. xfer_data / xfer_id are captured at grant
//   and held for the whole handshake.
//
//   Optional feature macro: SYNC_HS_TIMEOUT_EN (per-phase timeout, pulses timeout_err).
//
// Ports
//   clk_source        source-domain clock
//   rst_source        synchronous active-high reset
//   req_valid         per-requester request, held until its req_ready pulse
//   req_data          per-requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready         one-hot 1-cycle grant pulse
//   done              one-hot 1-cycle transfer-complete pulse
//   sig_level_source  level into the forward synchronizer
//   xfer_data         bundled data word, stable while busy
//   xfer_id           granted requester index, stable while busy
//   ack_level         returned acknowledge, already synchronized into clk_source
//   busy              high in REQ_HI and REQ_LO
//   timeout_err       1-cycle pulse on a phase timeout (always 0 without the macro)
module sync_hs_arbiter #(
   parameter int unsigned REQ_NUM     = 4,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned TIMEOUT_CYC = 255,
   localparam int unsigned IdWidth    = $clog2(REQ_NUM)
) (
   input  logic                          clk_source,
   input  logic                          rst_source,
   input  logic [REQ_NUM-1:0]            req_valid,
   input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data,
   output logic [REQ_NUM-1:0]            req_ready,
   output logic [REQ_NUM-1:0]            done,
   output logic                          sig_level_source,
   output logic [DATA_WIDTH-1:0]         xfer_data,
   output logic [IdWidth-1:0]            xfer_id,
   input  logic                          ack_level,
   output logic                          busy,
   output logic                          timeout_err
);

   if (REQ_NUM < 2 || REQ_NUM > 16 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_param
      $error("sync_hs_arbiter: parameter out of legal range");
   end

   typedef enum logic [1:0] {StIdle, StReqHi, StReqLo} state_e;

   localparam logic [IdWidth:0]   ReqNumExt = (IdWidth + 1)'(REQ_NUM);
   localparam logic [IdWidth-1:0] LastIdx   = IdWidth'(REQ_NUM - 1);

   state_e                  state_q, state_d;
   logic [IdWidth-1:0]      rr_ptr_q, rr_ptr_d;
   logic                    sig_level_q, sig_level_d;
   logic [REQ_NUM-1:0]      req_ready_q, req_ready_d;
   logic [REQ_NUM-1:0]      done_q, done_d;
   logic [DATA_WIDTH-1:0]   xfer_data_q, xfer_data_d;
   logic [IdWidth-1:0]      xfer_id_q, xfer_id_d;
   logic                    busy_q, busy_d;
   logic                    timeout_err_q, timeout_err_d;

`ifdef SYNC_HS_TIMEOUT_EN
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);
   logic [15:0] cnt_q, cnt_d;
   // Set when REQ_HI timed out, so the following REQ_LO exit reports no completion.
   logic        abort_q, abort_d;
`endif

   // Round-robin search: first set request at or after rr_ptr, wrapping modulo REQ_NUM.
   logic               grant_found;
   logic [IdWidth-1:0] grant_idx;
   logic [IdWidth:0]   cand;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned off = 0; off < REQ_NUM; off++) begin
         cand = {1'b0, rr_ptr_q} + (IdWidth + 1)'(off);
         if (cand >= ReqNumExt) begin
            cand = cand - ReqNumExt;
         end
         if (!grant_found && req_valid[cand[IdWidth-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[IdWidth-1:0];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      sig_level_d   = sig_level_q;
      req_ready_d   = '0;
      done_d        = '0;
      xfer_data_d   = xfer_data_q;
      xfer_id_d     = xfer_id_q;
      busy_d        = busy_q;
      timeout_err_d = 1'b0;
`ifdef SYNC_HS_TIMEOUT_EN
      cnt_d         = cnt_q;
      abort_d       = abort_q;
`endif
      unique case (state_q)
         StIdle: begin
            // A high ack here is left over from an earlier (possibly reset) handshake.
            if (grant_found && !ack_level) begin
               state_d                = StReqHi;
               sig_level_d            = 1'b1;
               busy_d                 = 1'b1;
               req_ready_d[grant_idx] = 1'b1;
               xfer_id_d              = grant_idx;
               xfer_data_d            = req_data[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
               rr_ptr_d               = (grant_idx == LastIdx) ? '0 : grant_idx + IdWidth'(1);
`ifdef SYNC_HS_TIMEOUT_EN
               cnt_d                  = '0;
               abort_d                = 1'b0;
`endif
            end
         end
         StReqHi: begin
            if (ack_level) begin
               state_d     = StReqLo;
               sig_level_d = 1'b0;
`ifdef SYNC_HS_TIMEOUT_EN
               cnt_d       = '0;
            end else if (cnt_q == TimeoutLast) begin
               state_d       = StReqLo;
               sig_level_d   = 1'b0;
               timeout_err_d = 1'b1;
               abort_d       = 1'b1;
               cnt_d         = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
`endif
            end
         end
         StReqLo: begin
            if (!ack_level) begin
               state_d = StIdle;
               busy_d  = 1'b0;
`ifdef SYNC_HS_TIMEOUT_EN
               cnt_d   = '0;
               if (!abort_q) begin
                  done_d[xfer_id_q] = 1'b1;
               end
            end else if (cnt_q == TimeoutLast) begin
               state_d       = StIdle;
               busy_d        = 1'b0;
               timeout_err_d = 1'b1;
               cnt_d         = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
`else
               done_d[xfer_id_q] = 1'b1;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_source) begin
      if (rst_source) begin
         state_q       <= StIdle;
         rr_ptr_q      <= '0;
         sig_level_q   <= 1'b0;
         req_ready_q   <= '0;
         done_q        <= '0;
         xfer_data_q   <= '0;
         xfer_id_q     <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
`ifdef SYNC_HS_TIMEOUT_EN
         cnt_q         <= '0;
         abort_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         sig_level_q   <= sig_level_d;
         req_ready_q   <= req_ready_d;
         done_q        <= done_d;
         xfer_data_q   <= xfer_data_d;
         xfer_id_q     <= xfer_id_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
`ifdef SYNC_HS_TIMEOUT_EN
         cnt_q         <= cnt_d;
         abort_q       <= abort_d;
`endif
      end
   end

   assign req_ready        = req_ready_q;
   assign done             = done_q;
   assign sig_level_source = sig_level_q;
   assign xfer_data        = xfer_data_q;
   assign xfer_id          = xfer_id_q;
   assign busy             = busy_q;
   assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_sync_hs_arbiter.sv
// Testbench for sync_hs_arbiter: a transaction-level model (phase number, pointer arithmetic,
// modulo search) predicts every output each cycle, plus directed checks with hand-computed
// values for the single-request, round-robin, stale-ack, reset and timeout scenarios.
module tb_sync_hs_arbiter;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int IDW = $clog2(N);
   localparam int TO  = 8;

   logic              clk_source = 1'b0;
   logic              rst_source = 1'b1;
   logic [N-1:0]      req_valid  = '0;
   logic [N*DW-1:0]   req_data   = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      done;
   logic              sig_level_source;
   logic [DW-1:0]     xfer_data;
   logic [IDW-1:0]    xfer_id;
   logic              ack_level;
   logic              busy;
   logic              timeout_err;

   // Return path: sig_level_source delayed 6 cycles, or a forced level.
   logic [5:0] sh        = '0;
   logic       force_en  = 1'b0;
   logic       force_val = 1'b0;
   assign ack_level = force_en ? force_val : sh[5];

   sync_hs_arbiter #(
      .REQ_NUM    (N),
      .DATA_WIDTH (DW),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk_source      (clk_source),
      .rst_source      (rst_source),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_ready       (req_ready),
      .done            (done),
      .sig_level_source(sig_level_source),
      .xfer_data       (xfer_data),
      .xfer_id         (xfer_id),
      .ack_level       (ack_level),
      .busy            (busy),
      .timeout_err     (timeout_err)
   );

   always #5 clk_source = ~clk_source;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;
   int grant_q[$];

   // Model state: phase 0 idle, 1 request high, 2 request low.
   int            m_phase = 0;
   int            m_ptr   = 0;
   int            m_cnt   = 0;
   bit            m_abort = 1'b0;
   logic [N-1:0]  m_ready = '0;
   logic [N-1:0]  m_done  = '0;
   logic          m_sig   = 1'b0;
   logic [DW-1:0] m_data  = '0;
   logic [IDW-1:0] m_id   = '0;
   logic          m_busy  = 1'b0;
   logic          m_terr  = 1'b0;

   task automatic model_step();
      int  w;
      bit  found;
      m_ready = '0;
      m_done  = '0;
      m_terr  = 1'b0;
      if (rst_source) begin
         m_phase = 0; m_ptr = 0; m_cnt = 0; m_abort = 1'b0;
         m_sig = 1'b0; m_data = '0; m_id = '0; m_busy = 1'b0;
      end else if (m_phase == 0) begin
         found = 1'b0;
         w     = 0;
         for (int o = 0; o < N; o++) begin
            if (!found && req_valid[(m_ptr + o) % N]) begin
               found = 1'b1;
               w     = (m_ptr + o) % N;
            end
         end
         if (found && !ack_level) begin
            m_ready[w] = 1'b1;
            m_id       = IDW'(w);
            m_data     = req_data[w*DW +: DW];
            m_ptr      = (w + 1) % N;
            m_sig      = 1'b1;
            m_busy     = 1'b1;
            m_phase    = 1;
            m_cnt      = 0;
            m_abort    = 1'b0;
         end
      end else if (m_phase == 1) begin
         if (ack_level) begin
            m_sig = 1'b0; m_phase = 2; m_cnt = 0;
         end else begin
`ifdef SYNC_HS_TIMEOUT_EN
            if (m_cnt == TO - 1) begin
               m_terr = 1'b1; m_sig = 1'b0; m_phase = 2; m_cnt = 0; m_abort = 1'b1;
            end else m_cnt++;
`endif
         end
      end else begin
         if (!ack_level) begin
            m_phase = 0; m_busy = 1'b0;
            if (!m_abort) m_done[m_id] = 1'b1;
         end else begin
`ifdef SYNC_HS_TIMEOUT_EN
            if (m_cnt == TO - 1) begin
               m_terr = 1'b1; m_phase = 0; m_busy = 1'b0;
            end else m_cnt++;
`endif
         end
      end
   endtask

   initial forever begin
      @(posedge clk_source);
      sh <= {sh[4:0], sig_level_source};
      model_step();
   end

   // Compare every cycle against the model; also log grants and completions.
   initial forever begin
      @(negedge clk_source);
      vectors++;
      if ({req_ready, done, sig_level_source, xfer_data, xfer_id, busy, timeout_err} !==
          {m_ready, m_done, m_sig, m_data, m_id, m_busy, m_terr}) begin
         miscompares++;
         $display("FAIL model t=%0t: dut rdy=%b done=%b sig=%b data=%h id=%0d busy=%b terr=%b | model rdy=%b done=%b sig=%b data=%h id=%0d busy=%b terr=%b",
                  $time, req_ready, done, sig_level_source, xfer_data, xfer_id, busy,
                  timeout_err, m_ready, m_done, m_sig, m_data, m_id, m_busy, m_terr);
      end
      if (req_ready != '0) grant_q.push_back(int'(xfer_id));
      if (done != '0) done_cnt++;
   end

   task automatic step();
      @(negedge clk_source);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (req_ready == '0 && n < 100) begin step(); n++; end
      if (n >= 100) check(name, 32'(n), 32'd0);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 200) begin step(); n++; end
      if (n >= 200) check(name, 32'(n), 32'd0);
   endtask

   task automatic do_reset();
      rst_source = 1'b1;
      step(); step();
      rst_source = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int hi, n, bad, d0;
      int exp_order[5] = '{0, 1, 2, 3, 0};

      // Reset state
      step(); step();
      check("rst_sig",  32'(sig_level_source), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdy",  32'(req_ready), 32'd0);
      check("rst_data", 32'(xfer_data), 32'd0);
      rst_source = 1'b0;
      step();

      // Single request from requester 2
      req_data[2*DW +: DW] = 8'hA5;
      req_data[1*DW +: DW] = 8'h3C;
      req_valid = 4'b0100;
      d0 = done_cnt;
      wait_ready("t1_grant_bound");
      check("t1_ready", 32'(req_ready), 32'h4);
      check("t1_id",    32'(xfer_id), 32'd2);
      check("t1_data",  32'(xfer_data), 32'hA5);
      req_valid = '0;
      hi = 0; n = 0; bad = 0;
      while (done == '0 && n < 60) begin
         if (sig_level_source) hi++;
         if (busy && (xfer_data !== 8'hA5 || xfer_id !== 2'd2)) bad++;
         step(); n++;
      end
      check("t1_sig_high_cycles", 32'(hi), 32'd7);
      check("t1_done", 32'(done), 32'h4);
      check("t1_stable", 32'(bad), 32'd0);
      step();
      check("t1_done_single", 32'(done_cnt - d0), 32'd1);
      step(); step();

      // Round-robin with all requests held
      do_reset();
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(8'h10 + i);
      grant_q.delete();
      d0 = done_cnt;
      req_valid = 4'hF;
      n = 0;
      while (grant_q.size() < 5 && n < 400) begin step(); n++; end
      req_valid = '0;
      wait_idle("t2_idle_bound");
      step(); step();
      check("t2_grants", 32'(grant_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) check("t2_order", 32'(grant_q[i]), 32'(exp_order[i]));
      check("t2_dones", 32'(done_cnt - d0), 32'd5);

      // Stale ack blocks the grant
      force_en = 1'b1; force_val = 1'b1;
      req_valid = 4'b0001;
      bad = 0;
      for (int i = 0; i < 5; i++) begin step(); if (req_ready != '0) bad++; end
      check("t3_no_grant", 32'(bad), 32'd0);
      force_val = 1'b0;
      step();
      check("t3_grant", 32'(req_ready), 32'h1);
      req_valid = '0;
      step(); step(); step();
      force_val = 1'b1;
      step(); step(); step();
      force_val = 1'b0;
      wait_idle("t3_idle_bound");
      check("t3_done", 32'(done), 32'h1);
      for (int i = 0; i < 8; i++) step();
      force_en = 1'b0;

      // Reset in the middle of a transfer (rr_ptr is 1 here)
      req_valid = 4'b0010;
      wait_ready("t4_grant_bound");
      check("t4_first_id", 32'(xfer_id), 32'd1);
      req_valid = '0;
      step(); step();
      d0 = done_cnt;
      rst_source = 1'b1;
      step();
      rst_source = 1'b0;
      check("t4_sig", 32'(sig_level_source), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 12; i++) step();
      check("t4_no_done", 32'(done_cnt - d0), 32'd0);
      req_valid = 4'hF;
      wait_ready("t4_regrant_bound");
      check("t4_ptr_reset", 32'(req_ready), 32'h1);
      req_valid = '0;
      wait_idle("t4_idle_bound");
      step(); step();

`ifdef SYNC_HS_TIMEOUT_EN
      // Ack stuck low: REQ_HI times out, then REQ_LO exits without done
      force_en = 1'b1; force_val = 1'b0;
      req_valid = 4'b0100;
      d0 = done_cnt;
      wait_ready("t5_grant_bound");
      req_valid = '0;
      n = 0;
      while (!timeout_err && n < 40) begin step(); n++; end
      check("t5_latency", 32'(n), 32'd8);
      check("t5_sig", 32'(sig_level_source), 32'd0);
      step();
      check("t5_idle", 32'(busy), 32'd0);
      step(); step();
      check("t5_no_done", 32'(done_cnt - d0), 32'd0);
      force_en = 1'b0;
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
